fetch_unit: RTL and testbench

//  Instruction fetch stage upstream of control_unit. Holds the PC and issues word reads to instruction memory.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/fetch_unit.sv | 158 +++++++++++++++
 tb/tb_fetch_unit.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional feature macro: FETCH_PERF_CNT_EN (performance counters in fetch_unit).
package fetch_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  // Sequential fetch step and architectural PC read offset
  localparam int PC_INCR        = 4;
  localparam int PC_READ_OFFSET = 8;

  // Instruction field positions consumed by control_unit
  localparam int COND_MSB  = 31;
  localparam int COND_W    = 4;
  localparam int OP_MSB    = 27;
  localparam int OP_W      = 2;
  localparam int FUNCT_MSB = 25;
  localparam int FUNCT_W   = 6;
  localparam int RD_MSB    = 15;
  localparam int RD_W      = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO buffering fetched {instruction, address} entries.
// A clear request empties the buffer and takes priority over push and pop.
module fetch_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign rdata   = mem[rd_ptr];

  // Storage array; data needs no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; clear behaves like reset
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word reads,
// buffers returned words and presents the head instruction split into fields.
// Optional feature macro: FETCH_PERF_CNT_EN adds fetched_cnt / flushed_cnt.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_valid,
  input  logic              pc_src,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc8,
  output logic [3:0]        cond,
  output logic [1:0]        op,
  output logic [5:0]        funct,
  output logic [3:0]        rd
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetched_cnt,
  output logic [31:0]       flushed_cnt
`endif
);

  localparam int                ENTRY_W    = 32 + ADDR_W;
  localparam int                CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  fetch_state_e       state;
  fetch_state_e       next_state;
  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  next_pc;
  logic [ADDR_W-1:0]  redirect_pc;
  logic [ADDR_W-1:0]  head_pc;
  logic               fifo_push;
  logic               fifo_pop;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic               fifo_empty;
  logic               fifo_full;
  logic [CNT_W-1:0]   fifo_count;

  assign redirect_pc = branch_target & ALIGN_MASK;
  assign imem_addr   = fetch_pc;
  assign fifo_pop    = instr_valid && instr_ready && !pc_src;

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (pc_src),
    .wdata ({imem_rdata, fetch_pc}),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Head entry drives decode directly, split into control_unit fields
  assign instr_valid = !fifo_empty;
  assign instr       = fifo_rdata[ENTRY_W-1:ADDR_W];
  assign head_pc     = fifo_rdata[ADDR_W-1:0];
  assign instr_pc8   = head_pc + ADDR_W'(PC_READ_OFFSET);
  assign cond        = instr[COND_MSB -: COND_W];
  assign op          = instr[OP_MSB -: OP_W];
  assign funct       = instr[FUNCT_MSB -: FUNCT_W];
  assign rd          = instr[RD_MSB -: RD_W];

  // Sequencer: a redirect beats push, pop and request; a response still in
  // flight during a redirect is parked in DISCARD so it cannot be mistaken
  // for the first word at the new target
  always_comb begin
    next_state = state;
    next_pc    = fetch_pc;
    imem_req   = 1'b0;
    fifo_push  = 1'b0;
    if (rst) begin
      next_state = FETCH;
    end else if (pc_src) begin
      next_pc = redirect_pc;
      case (state)
        FETCH:   next_state = FETCH;
        WAIT:    next_state = imem_valid ? FETCH : DISCARD;
        DISCARD: next_state = imem_valid ? FETCH : DISCARD;
        default: next_state = FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (fifo_count < CNT_W'(FIFO_DEPTH)) begin
            imem_req   = 1'b1;
            next_state = WAIT;
          end
        end
        WAIT: begin
          if (imem_valid) begin
            fifo_push  = !fifo_full;
            next_pc    = fetch_pc + ADDR_W'(PC_INCR);
            next_state = FETCH;
          end
        end
        DISCARD: begin
          if (imem_valid) begin
            next_state = FETCH;
          end
        end
        default: next_state = FETCH;
      endcase
    end
  end

  // State and PC registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= next_state;
      fetch_pc <= next_pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic        dropped_resp;
  logic [32:0] flush_sum;

  assign dropped_resp = pc_src && (state == WAIT) && imem_valid;
  assign flush_sum    = {1'b0, flushed_cnt} + 33'(fifo_count) + 33'(dropped_resp);

  // Saturating counters of delivered and flushed instructions
  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_cnt <= '0;
      flushed_cnt <= '0;
    end else begin
      if (fifo_push && (fetched_cnt != '1)) begin
        fetched_cnt <= fetched_cnt + 32'd1;
      end
      if (pc_src) begin
        flushed_cnt <= flush_sum[32] ? '1 : flush_sum[31:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a latency-programmable
// instruction memory responder. Optional macro: FETCH_PERF_CNT_EN.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        pc_src;
  logic [31:0] branch_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc8;
  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rd;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_cnt;
  logic [31:0] flushed_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int mem_lat      = 1;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } resp_t;

  resp_t       resp_q[$];
  logic [31:0] req_log[$];

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_valid    (imem_valid),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc8     (instr_pc8),
    .cond          (cond),
    .op            (op),
    .funct         (funct),
    .rd            (rd)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetched_cnt   (fetched_cnt),
    .flushed_cnt   (flushed_cnt)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents: address 0 holds a known ALU instruction, others tag the address
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0) return 32'hE290_0002;
    return 32'hA000_0000 | addr;
  endfunction

  // Memory responder: answers each sampled request mem_lat cycles later
  initial begin
    int    cycle_cnt;
    resp_t r;
    cycle_cnt  = 0;
    imem_valid = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      cycle_cnt++;
      imem_valid = 1'b0;
      if (resp_q.size() > 0 && resp_q[0].due <= cycle_cnt) begin
        imem_valid = 1'b1;
        imem_rdata = mem_word(resp_q[0].addr);
        void'(resp_q.pop_front());
      end
      #4;
      if (imem_req === 1'b1) begin
        req_log.push_back(imem_addr);
        r.due  = cycle_cnt + mem_lat;
        r.addr = imem_addr;
        resp_q.push_back(r);
      end
    end
  end

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  // Holds reset long enough to swallow any in-flight response, returns on the release edge
  task automatic apply_reset();
    rst           = 1'b1;
    pc_src        = 1'b0;
    branch_target = '0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    req_log.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if (imem_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_req: got %0b expected 0", imem_req);
    end
    tests_run++;
    if (instr_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_valid: got %0b expected 0", instr_valid);
    end
`ifdef FETCH_PERF_CNT_EN
    tests_run++;
    if (fetched_cnt !== 32'd0 || flushed_cnt !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_cnt: got %0d/%0d expected 0/0", fetched_cnt, flushed_cnt);
    end
`endif
  endtask

  task automatic test_basic_fetch();
    logic [31:0] exp_addr [3];
    logic [31:0] got;
    exp_addr    = '{32'h0, 32'h4, 32'h8};
    instr_ready = 1'b1;
    mem_lat     = 1;
    apply_reset();
    #1;
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL basic_first_req: got req=%0b addr=%h expected req=1 addr=0", imem_req, imem_addr);
    end
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (instr_valid !== 1'b1 || instr !== 32'hE290_0002) begin
      tests_failed++;
      $display("[TB] FAIL basic_instr0: got v=%0b %h expected v=1 e2900002", instr_valid, instr);
    end
    tests_run++;
    if (cond !== 4'hE || op !== 2'd0 || funct !== 6'b101001 || rd !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL basic_fields: got cond=%h op=%0d funct=%b rd=%0d expected cond=e op=0 funct=101001 rd=0",
               cond, op, funct, rd);
    end
    tests_run++;
    if (instr_pc8 !== 32'h8) begin
      tests_failed++;
      $display("[TB] FAIL basic_pc8_0: got %h expected 00000008", instr_pc8);
    end
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (instr_valid !== 1'b1 || instr !== 32'hA000_0004 || instr_pc8 !== 32'hC) begin
      tests_failed++;
      $display("[TB] FAIL basic_instr1: got v=%0b %h pc8=%h expected v=1 a0000004 pc8=0000000c",
               instr_valid, instr, instr_pc8);
    end
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      got = (i < req_log.size()) ? req_log[i] : 32'hxxxx_xxxx;
      tests_run++;
      if (got !== exp_addr[i]) begin
        tests_failed++;
        $display("[TB] FAIL basic_addr%0d: got %h expected %h", i, got, exp_addr[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    instr_ready = 1'b0;
    mem_lat     = 1;
    apply_reset();
    repeat (5) @(negedge clk);
    #1;
    tests_run++;
    if (req_log.size() != 2 || req_log[0] !== 32'h0 || req_log[1] !== 32'h4) begin
      tests_failed++;
      $display("[TB] FAIL bp_req_count: got %0d requests expected 2 (0,4)", req_log.size());
    end
    tests_run++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr !== 32'hE290_0002) begin
      tests_failed++;
      $display("[TB] FAIL bp_full: got req=%0b v=%0b %h expected req=0 v=1 e2900002",
               imem_req, instr_valid, instr);
    end
    @(negedge clk);
    instr_ready = 1'b1;
    #1;
    tests_run++;
    if (imem_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bp_pop_cycle_req: got %0b expected 0", imem_req);
    end
    @(negedge clk);
    instr_ready = 1'b0;
    #1;
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      tests_failed++;
      $display("[TB] FAIL bp_resume: got req=%0b addr=%h expected req=1 addr=00000008", imem_req, imem_addr);
    end
    tests_run++;
    if (instr !== 32'hA000_0004 || instr_pc8 !== 32'hC) begin
      tests_failed++;
      $display("[TB] FAIL bp_head: got %h pc8=%h expected a0000004 pc8=0000000c", instr, instr_pc8);
    end
  endtask

  task automatic test_redirect_full();
    instr_ready = 1'b0;
    mem_lat     = 1;
    apply_reset();
    repeat (5) @(negedge clk);
    pc_src        = 1'b1;
    branch_target = 32'h103;
    #1;
    tests_run++;
    if (imem_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL redir_req_same: got %0b expected 0", imem_req);
    end
    @(negedge clk);
    pc_src = 1'b0;
    #1;
    tests_run++;
    if (instr_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL redir_flush: got %0b expected 0", instr_valid);
    end
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      tests_failed++;
      $display("[TB] FAIL redir_target: got req=%0b addr=%h expected req=1 addr=00000100", imem_req, imem_addr);
    end
`ifdef FETCH_PERF_CNT_EN
    tests_run++;
    if (flushed_cnt !== 32'd2 || fetched_cnt !== 32'd2) begin
      tests_failed++;
      $display("[TB] FAIL redir_cnt: got fetched=%0d flushed=%0d expected 2/2", fetched_cnt, flushed_cnt);
    end
`endif
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (instr_valid !== 1'b1 || instr !== 32'hA000_0100 || instr_pc8 !== 32'h108) begin
      tests_failed++;
      $display("[TB] FAIL redir_new_instr: got v=%0b %h pc8=%h expected v=1 a0000100 pc8=00000108",
               instr_valid, instr, instr_pc8);
    end
  endtask

  task automatic test_redirect_wait();
    instr_ready = 1'b1;
    mem_lat     = 3;
    apply_reset();
    @(negedge clk);
    pc_src        = 1'b1;
    branch_target = 32'h40;
    @(negedge clk);
    pc_src = 1'b0;
    #1;
    tests_run++;
    if (imem_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL wait_discard_req: got %0b expected 0", imem_req);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL wait_drop: got req=%0b v=%0b expected req=0 v=0", imem_req, instr_valid);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      tests_failed++;
      $display("[TB] FAIL wait_target: got req=%0b addr=%h expected req=1 addr=00000040", imem_req, imem_addr);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (instr_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL wait_no_stale%0d: got %0b expected 0", i, instr_valid);
      end
      @(negedge clk);
      #1;
    end
    tests_run++;
    if (instr_valid !== 1'b1 || instr !== 32'hA000_0040 || instr_pc8 !== 32'h48) begin
      tests_failed++;
      $display("[TB] FAIL wait_new_instr: got v=%0b %h pc8=%h expected v=1 a0000040 pc8=00000048",
               instr_valid, instr, instr_pc8);
    end
  endtask

  task automatic test_back_to_back();
    instr_ready = 1'b1;
    mem_lat     = 1;
    apply_reset();
    @(negedge clk);
    pc_src        = 1'b1;
    branch_target = 32'h80;
    #1;
    tests_run++;
    if (imem_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_req_same: got %0b expected 0", imem_req);
    end
    @(negedge clk);
    pc_src = 1'b0;
    #1;
    tests_run++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h80) begin
      tests_failed++;
      $display("[TB] FAIL b2b_dropped: got v=%0b req=%0b addr=%h expected v=0 req=1 addr=00000080",
               instr_valid, imem_req, imem_addr);
    end
`ifdef FETCH_PERF_CNT_EN
    tests_run++;
    if (flushed_cnt !== 32'd1) begin
      tests_failed++;
      $display("[TB] FAIL b2b_flushed: got %0d expected 1", flushed_cnt);
    end
`endif
    repeat (2) @(negedge clk);
    instr_ready = 1'b0;
    #1;
    tests_run++;
    if (instr_valid !== 1'b1 || instr !== 32'hA000_0080) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first: got v=%0b %h expected v=1 a0000080", instr_valid, instr);
    end
    @(negedge clk);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    #1;
    tests_run++;
    if (instr_valid !== 1'b1 || instr !== 32'hA000_0084 || instr_pc8 !== 32'h8C) begin
      tests_failed++;
      $display("[TB] FAIL b2b_pushpop_head: got v=%0b %h pc8=%h expected v=1 a0000084 pc8=0000008c",
               instr_valid, instr, instr_pc8);
    end
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h88) begin
      tests_failed++;
      $display("[TB] FAIL b2b_pushpop_count: got req=%0b addr=%h expected req=1 addr=00000088",
               imem_req, imem_addr);
    end
`ifdef FETCH_PERF_CNT_EN
    tests_run++;
    if (fetched_cnt !== 32'd2) begin
      tests_failed++;
      $display("[TB] FAIL b2b_fetched: got %0d expected 2", fetched_cnt);
    end
`endif
  endtask

  task automatic test_reset_in_wait();
    instr_ready = 1'b1;
    mem_lat     = 1;
    apply_reset();
    pc_src        = 1'b1;
    branch_target = 32'h200;
    @(negedge clk);
    pc_src  = 1'b0;
    mem_lat = 2;
    #1;
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      tests_failed++;
      $display("[TB] FAIL rw_pre_req: got req=%0b addr=%h expected req=1 addr=00000200", imem_req, imem_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if (imem_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rw_req_in_reset: got %0b expected 0", imem_req);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rw_restart: got req=%0b addr=%h v=%0b expected req=1 addr=00000000 v=0",
               imem_req, imem_addr, instr_valid);
    end
`ifdef FETCH_PERF_CNT_EN
    tests_run++;
    if (fetched_cnt !== 32'd0 || flushed_cnt !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL rw_cnt: got %0d/%0d expected 0/0", fetched_cnt, flushed_cnt);
    end
`endif
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      tests_run++;
      if (instr_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL rw_late_dropped%0d: got %0b expected 0", i, instr_valid);
      end
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (instr_valid !== 1'b1 || instr !== 32'hE290_0002 || instr_pc8 !== 32'h8) begin
      tests_failed++;
      $display("[TB] FAIL rw_first_instr: got v=%0b %h pc8=%h expected v=1 e2900002 pc8=00000008",
               instr_valid, instr, instr_pc8);
    end
  endtask

  // Scenario sequence
  initial begin
    rst           = 1'b1;
    pc_src        = 1'b0;
    branch_target = '0;
    instr_ready   = 1'b0;
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_redirect_full();
    test_redirect_wait();
    test_back_to_back();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
